pwm_multi_channel: RTL
======================

// Module: pwm_multi_channel
// PURPOSE
//  Parametrised successor to the fixed 2-bit pwm_0 component. NUM_CH PWM outputs share one prescaled
//  period counter; duty and polarity are set per channel. Sits in soc_system as an Avalon-MM slave behind
//  the HPS lightweight bridge and drives motor/LED PWM pins. Shadow registers apply glitch-free at period wrap.
// PARAMETERS
//  NUM_CH  8   number of PWM outputs, 1..32
//  CNT_W   16  width of prescaler, period and duty, 2..32
//  ADDR_W  6   Avalon word-address width, fixed map below
// PORTS
//  clk        in   1        system clock
//  reset_n    in   1        asynchronous active-low reset
//  address    in   ADDR_W   Avalon word address
//  write      in   1        write strobe, no waitrequest
//  writedata  in   32       write data, LSB-aligned
//  read       in   1        read strobe
//  readdata   out  32       read data, fixed latency 1
//  pwm        out  NUM_CH   PWM outputs, registered
//  irq        out  1        period-wrap interrupt, level
// BEHAVIOUR
//  Register map (word addr; reads return the shadow value):
//   0x00 CTRL  [0] EN; [1] FORCE_LOAD, write-1 self-clearing, reads 0
//   0x01 PRESCALE  0x02 PERIOD  0x05 COUNTER (RO, active cnt)  0x06 POLARITY [NUM_CH-1:0]
//   0x03 STATUS [0] WRAP, write-1-to-clear  0x04 IRQ_MASK [0]   0x20+i DUTY[i], i<NUM_CH
//   Unmapped or i>=NUM_CH: writes ignored, reads 0.
//  Reset: CTRL=0, PRESCALE=0, PERIOD=all-ones, DUTY=0, POLARITY=0, pre_cnt=cnt=0,
//   shadows and actives equal; pwm=0, readdata=0, irq=0, STATUS=0.
//  Prescaler: tick when pre_cnt==PRESCALE, then pre_cnt<=0. PRESCALE=0 ticks every cycle.
//  Counter: on tick, cnt counts 0..period_act inclusive; wrap = tick && cnt==period_act -> cnt<=0.
//   At wrap, copy PERIOD, DUTY[*] and POLARITY shadows into the actives.
//   period_act=0: wrap on every tick.
//  EN 0->1 edge or FORCE_LOAD: next cycle pre_cnt=cnt=0 and actives loaded.
//   EN=0 holds pre_cnt and cnt at 0.
//  Output: pwm[i] <= EN ? ((cnt < duty_act[i]) ^ pol_act[i]) : pol_act[i]. One cycle after cnt.
//   duty=0 gives 0% active; duty>period_act gives 100% active (no glitch at wrap).
//  Write and wrap in the same cycle: the actives take the pre-write shadow value.
//   The new value applies at the next wrap.
//  Read: readdata valid the cycle after read; holds its value otherwise.
//   COUNTER read returns cnt sampled in the read cycle.
//  reset_n asserted mid-period: all state returns to reset values immediately (async).
// CONFIGURATION
//  PWM_IRQ_EN defined: STATUS.WRAP set on every wrap while EN=1.
//   W1C in the same cycle as a wrap: the set wins.
//   irq = WRAP & IRQ_MASK[0], registered.
//  PWM_IRQ_EN undefined: STATUS and IRQ_MASK read 0, writes are ignored, irq tied 0.
//   No flag logic is synthesised.
// STRUCTURE
//  pwm_pkg: register address localparams (ADDR_CTRL, ADDR_PRESCALE, ADDR_PERIOD, ADDR_STATUS,
//   ADDR_IRQ_MASK, ADDR_COUNTER, ADDR_POLARITY, ADDR_DUTY_BASE) and CTRL bit indices.
//  Sub-module pwm_channel_cmp: per-channel active duty/polarity register, load on wrap,
//   compare and output flop. Generate-instantiated NUM_CH times.
//  Top level holds the CSR decode, prescaler, counter and the optional IRQ.
// TESTING
//  1 PRESCALE=0, PERIOD=9, DUTY0=3, EN=1 -> pwm[0] high 3 cycles, low 7, period 10 clk.
//  2 PRESCALE=1, PERIOD=3, DUTY1=0 and DUTY2=5 -> pwm[1] constant 0, pwm[2] constant 1.
//    COUNTER advances every 2 clk.
//  3 Mid-period, write DUTY0=7 and POLARITY=1 -> old waveform until wrap.
//    From cnt=0: inverted, low 7 cycles. Repeat with the write on the wrap cycle: change delayed one period.
//  4 FORCE_LOAD with PERIOD=4 while cnt=8 -> next cycle cnt=0, new period active.
//    EN=0 -> pwm=POLARITY and COUNTER reads 0.
//  5 PWM_IRQ_EN, IRQ_MASK=1 -> irq rises the cycle after wrap.
//    W1C on STATUS clears it; W1C coincident with a wrap leaves it set. Without the macro irq stays 0.
//  6 Assert reset_n mid-period -> pwm, irq, readdata 0 at once. Read back all registers at reset values.
//    Out-of-range DUTY (0x20+NUM_CH) reads 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - register map and CTRL bit positions shared by the PWM block
package pwm_pkg;

  localparam int ADDR_CTRL      = 'h00;
  localparam int ADDR_PRESCALE  = 'h01;
  localparam int ADDR_PERIOD    = 'h02;
  localparam int ADDR_STATUS    = 'h03;
  localparam int ADDR_IRQ_MASK  = 'h04;
  localparam int ADDR_COUNTER   = 'h05;
  localparam int ADDR_POLARITY  = 'h06;
  localparam int ADDR_DUTY_BASE = 'h20;

  localparam int CTRL_EN_BIT         = 0;
  localparam int CTRL_FORCE_LOAD_BIT = 1;

endpackage

// File: rtl/pwm_channel_cmp.sv
// rtl/pwm_channel_cmp.sv - one PWM channel: active duty/polarity, compare and output flop
module pwm_channel_cmp #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [CNT_W-1:0] i_duty_sh,
  input  logic             i_pol_sh,
  output logic             o_pwm
);

  logic [CNT_W-1:0] r_duty_act;
  logic             r_pol_act;
  logic             r_pwm;

  // Active settings follow the shadows only at a period wrap or a forced/enable load
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_duty_act <= '0;
      r_pol_act  <= 1'b0;
    end else if (i_load) begin
      r_duty_act <= i_duty_sh;
      r_pol_act  <= i_pol_sh;
    end
  end

  // Output flop: compare against the running count, idle at the polarity level when disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= i_en ? ((i_cnt < r_duty_act) ^ r_pol_act) : r_pol_act;
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_multi_channel.sv
// rtl/pwm_multi_channel.sv - multi-channel PWM with Avalon-MM CSRs; wrap IRQ built only with PWM_IRQ_EN
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int NUM_CH = 8,
  parameter int CNT_W  = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic              read,
  output logic [31:0]       readdata,
  output logic [NUM_CH-1:0] pwm,
  output logic              irq
);

  logic              r_en;
  logic [CNT_W-1:0]  r_prescale;
  logic [CNT_W-1:0]  r_period_sh;
  logic [CNT_W-1:0]  r_period_act;
  logic [CNT_W-1:0]  r_duty_sh [NUM_CH];
  logic [NUM_CH-1:0] r_pol_sh;
  logic [CNT_W-1:0]  r_pre_cnt;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_readdata;

  logic              w_wr_ctrl;
  logic              w_start;
  logic              w_tick;
  logic              w_wrap;
  logic              w_load;
  logic [31:0]       w_rd_data;
  logic [NUM_CH-1:0] w_pwm;
  logic              w_unused_wdata;

  assign w_wr_ctrl = write && (address == ADDR_W'(ADDR_CTRL));
  // A restart happens on FORCE_LOAD or on the EN 0->1 edge
  assign w_start   = w_wr_ctrl && (writedata[CTRL_FORCE_LOAD_BIT] ||
                                   (writedata[CTRL_EN_BIT] && !r_en));
  // >= also recovers if PRESCALE is lowered below the running prescaler count
  assign w_tick    = r_en && (r_pre_cnt >= r_prescale);
  assign w_wrap    = w_tick && (r_cnt == r_period_act);
  assign w_load    = w_wrap || w_start;
  assign w_unused_wdata = ^writedata;

  // Shadow registers written from the bus
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en        <= 1'b0;
      r_prescale  <= '0;
      r_period_sh <= '1;
      r_pol_sh    <= '0;
      for (int i = 0; i < NUM_CH; i++) r_duty_sh[i] <= '0;
    end else if (write) begin
      if (address == ADDR_W'(ADDR_CTRL))     r_en        <= writedata[CTRL_EN_BIT];
      if (address == ADDR_W'(ADDR_PRESCALE)) r_prescale  <= writedata[CNT_W-1:0];
      if (address == ADDR_W'(ADDR_PERIOD))   r_period_sh <= writedata[CNT_W-1:0];
      if (address == ADDR_W'(ADDR_POLARITY)) r_pol_sh    <= writedata[NUM_CH-1:0];
      for (int i = 0; i < NUM_CH; i++) begin
        if (address == ADDR_W'(ADDR_DUTY_BASE + i)) r_duty_sh[i] <= writedata[CNT_W-1:0];
      end
    end
  end

  // Prescaler, period counter and active period; counters held at zero while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pre_cnt    <= '0;
      r_cnt        <= '0;
      r_period_act <= '1;
    end else begin
      if (w_load) r_period_act <= r_period_sh;
      if (w_start || !r_en) begin
        r_pre_cnt <= '0;
        r_cnt     <= '0;
      end else if (w_tick) begin
        r_pre_cnt <= '0;
        r_cnt     <= w_wrap ? '0 : r_cnt + CNT_W'(1);
      end else begin
        r_pre_cnt <= r_pre_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PWM_IRQ_EN
  logic r_wrap_flag;
  logic r_irq_mask;
  logic r_irq;
  logic w_flag_nxt;
  logic w_mask_nxt;

  // Next flag/mask values; a wrap beats a simultaneous write-1-to-clear
  always_comb begin
    w_flag_nxt = r_wrap_flag;
    w_mask_nxt = r_irq_mask;
    if (write && (address == ADDR_W'(ADDR_STATUS)) && writedata[0]) w_flag_nxt = 1'b0;
    if (w_wrap) w_flag_nxt = 1'b1;
    if (write && (address == ADDR_W'(ADDR_IRQ_MASK))) w_mask_nxt = writedata[0];
  end

  // Wrap flag, mask and registered level interrupt
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrap_flag <= 1'b0;
      r_irq_mask  <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_wrap_flag <= w_flag_nxt;
      r_irq_mask  <= w_mask_nxt;
      r_irq       <= w_flag_nxt & w_mask_nxt;
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Read mux: shadow values, live counter, zero for unmapped words
  always_comb begin
    w_rd_data = '0;
    case (address)
      ADDR_W'(ADDR_CTRL):     w_rd_data[CTRL_EN_BIT] = r_en;
      ADDR_W'(ADDR_PRESCALE): w_rd_data[CNT_W-1:0]   = r_prescale;
      ADDR_W'(ADDR_PERIOD):   w_rd_data[CNT_W-1:0]   = r_period_sh;
      ADDR_W'(ADDR_COUNTER):  w_rd_data[CNT_W-1:0]   = r_cnt;
      ADDR_W'(ADDR_POLARITY): w_rd_data[NUM_CH-1:0]  = r_pol_sh;
`ifdef PWM_IRQ_EN
      ADDR_W'(ADDR_STATUS):   w_rd_data[0]           = r_wrap_flag;
      ADDR_W'(ADDR_IRQ_MASK): w_rd_data[0]           = r_irq_mask;
`else
      ADDR_W'(ADDR_STATUS),
      ADDR_W'(ADDR_IRQ_MASK): w_rd_data              = '0;
`endif
      default:                w_rd_data              = '0;
    endcase
    for (int i = 0; i < NUM_CH; i++) begin
      if (address == ADDR_W'(ADDR_DUTY_BASE + i)) w_rd_data[CNT_W-1:0] = r_duty_sh[i];
    end
  end

  // Read data register: one-cycle latency, holds between reads
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (read) begin
      r_readdata <= w_rd_data;
    end
  end

  assign readdata = r_readdata;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    pwm_channel_cmp #(
      .CNT_W(CNT_W)
    ) u_cmp (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_load),
      .i_en     (r_en),
      .i_cnt    (r_cnt),
      .i_duty_sh(r_duty_sh[g]),
      .i_pol_sh (r_pol_sh[g]),
      .o_pwm    (w_pwm[g])
    );
  end

  assign pwm = w_pwm;

endmodule
